xadc_mux_scan_sequencer: RTL and testbench

Controller that sequences the external analog multiplexer (XADC_MUXADDR) and the XADC dynamic reconfiguration port (DRP) to sample neuromorphic ASIC analog outputs channel by channel. For each enabled channel it drives the mux address, waits a settle interval, waits for a fresh XADC end-of-conversion, reads the VP/VN result over DRP and emits a tagged 12-bit sample. It sits between the AXI-lite register bank, which supplies the start, continuous and mask controls and stores the samples, and the XADC primitive.

---
 rtl/xadc_mux_scan_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_xadc_mux_scan_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_mux_scan_sequencer.sv
// xadc_mux_scan_sequencer
// Steps the external analog mux over the enabled channels, waits for the
// mux output to settle, waits for a fresh XADC end-of-conversion, reads the
// VP/VN result over DRP and emits one tagged 12-bit sample per channel.
// Optional build macro: THRESHOLD_EN adds the threshold input and the
// per-channel spike_vec flags (result >= threshold).
module xadc_mux_scan_sequencer #(
    parameter int         NUM_CH        = 16,
    parameter int         SETTLE_CYCLES = 100,
    parameter int         EOC_TIMEOUT   = 4096,
    parameter logic [6:0] DRP_ADDR      = 7'h03
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
`ifdef THRESHOLD_EN
    input  logic [11:0]       threshold,
    output logic [NUM_CH-1:0] spike_vec,
`endif
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              eoc,
    input  logic              drp_drdy,
    input  logic [15:0]       drp_do,
    output logic [3:0]        mux_addr,
    output logic              drp_den,
    output logic [6:0]        drp_daddr,
    output logic              result_wr,
    output logic [3:0]        result_ch,
    output logic [11:0]       result_data,
    output logic              result_err,
    output logic              busy,
    output logic              scan_done
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TOW = $clog2(EOC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_WAIT_EOC, ST_DRP_REQ, ST_DRP_WAIT, ST_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [3:0]        mux_addr_q, mux_addr_d;
    logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TOW-1:0]    to_cnt_q, to_cnt_d;
    logic              drp_den_q, drp_den_d;
    logic              result_wr_q, result_wr_d;
    logic [3:0]        result_ch_q, result_ch_d;
    logic [11:0]       result_data_q, result_data_d;
    logic              result_err_q, result_err_d;
    logic              busy_q, busy_d;
    logic              scan_done_q, scan_done_d;
    // Where WRITE goes next: decided on entry so scan_done/busy line up
    // with the last result_wr.
    logic              go_q, go_d;
    logic [3:0]        next_ch_q, next_ch_d;
`ifdef THRESHOLD_EN
    logic [NUM_CH-1:0] spike_vec_q, spike_vec_d;
`endif

    logic        enter_write;
    logic [11:0] wr_data;
    logic        wr_err;
    logic [4:0]  nxt_in_scan;   // {found, channel} above current channel
    logic [4:0]  first_in_new;  // {found, channel} lowest in live ch_mask

    // Low nibble of drp_do is below the 12-bit result and is not used.
    logic unused_drp_lsb;
    assign unused_drp_lsb = ^drp_do[3:0];

    // Lowest set bit of m strictly above index 'after' (-1 = from bit 0).
    function automatic logic [4:0] find_ch(input logic [NUM_CH-1:0] m,
                                           input int after);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i > after) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        mux_addr_d    = mux_addr_q;
        settle_cnt_d  = settle_cnt_q;
        to_cnt_d      = to_cnt_q;
        drp_den_d     = 1'b0;
        result_wr_d   = 1'b0;
        result_ch_d   = result_ch_q;
        result_data_d = result_data_q;
        result_err_d  = result_err_q;
        busy_d        = busy_q;
        scan_done_d   = 1'b0;
        go_d          = go_q;
        next_ch_d     = next_ch_q;
        enter_write   = 1'b0;
        wr_data       = 12'hFFF;
        wr_err        = 1'b1;
        nxt_in_scan   = find_ch(mask_q, int'(mux_addr_q));
        first_in_new  = find_ch(ch_mask, -1);
`ifdef THRESHOLD_EN
        spike_vec_d   = spike_vec_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    if (first_in_new[4]) begin
                        mux_addr_d   = first_in_new[3:0];
                        settle_cnt_d = SCW'(SETTLE_CYCLES);
                        busy_d       = 1'b1;
                        state_d      = ST_SETTLE;
                    end else begin
                        scan_done_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // eoc is ignored here: any conversion in flight predates the mux change
                if (settle_cnt_q == '0) begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_EOC;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_WAIT_EOC: begin
                if (eoc) begin
                    drp_den_d = 1'b1;
                    state_d   = ST_DRP_REQ;
                end else if (to_cnt_q == TOW'(EOC_TIMEOUT - 1)) begin
                    enter_write = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_DRP_REQ: begin
                state_d = ST_DRP_WAIT;
            end
            ST_DRP_WAIT: begin
                if (drp_drdy) begin
                    enter_write = 1'b1;
                    wr_data     = drp_do[15:4];
                    wr_err      = 1'b0;
                end
            end
            ST_WRITE: begin
                if (go_q) begin
                    mux_addr_d   = next_ch_q;
                    settle_cnt_d = SCW'(SETTLE_CYCLES);
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_write) begin
            state_d       = ST_WRITE;
            result_wr_d   = 1'b1;
            result_ch_d   = mux_addr_q;
            result_data_d = wr_data;
            result_err_d  = wr_err;
            if (nxt_in_scan[4]) begin
                go_d      = 1'b1;
                next_ch_d = nxt_in_scan[3:0];
            end else begin
                scan_done_d = 1'b1;
                if (continuous) begin
                    mask_d    = ch_mask;
                    go_d      = first_in_new[4];
                    next_ch_d = first_in_new[3:0];
                    busy_d    = first_in_new[4];
                end else begin
                    go_d   = 1'b0;
                    busy_d = 1'b0;
                end
            end
`ifdef THRESHOLD_EN
            for (int i = 0; i < NUM_CH; i++) begin
                if (4'(i) == mux_addr_q)
                    spike_vec_d[i] = !wr_err && (wr_data >= threshold);
            end
`endif
        end
    end

    // State and output registers; reset aborts a scan without any strobe.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            mux_addr_q    <= '0;
            settle_cnt_q  <= '0;
            to_cnt_q      <= '0;
            drp_den_q     <= 1'b0;
            result_wr_q   <= 1'b0;
            result_ch_q   <= '0;
            result_data_q <= '0;
            result_err_q  <= 1'b0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            go_q          <= 1'b0;
            next_ch_q     <= '0;
`ifdef THRESHOLD_EN
            spike_vec_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            mux_addr_q    <= mux_addr_d;
            settle_cnt_q  <= settle_cnt_d;
            to_cnt_q      <= to_cnt_d;
            drp_den_q     <= drp_den_d;
            result_wr_q   <= result_wr_d;
            result_ch_q   <= result_ch_d;
            result_data_q <= result_data_d;
            result_err_q  <= result_err_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            go_q          <= go_d;
            next_ch_q     <= next_ch_d;
`ifdef THRESHOLD_EN
            spike_vec_q   <= spike_vec_d;
`endif
        end
    end

    assign mux_addr    = mux_addr_q;
    assign drp_den     = drp_den_q;
    assign drp_daddr   = DRP_ADDR;
    assign result_wr   = result_wr_q;
    assign result_ch   = result_ch_q;
    assign result_data = result_data_q;
    assign result_err  = result_err_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
`ifdef THRESHOLD_EN
    assign spike_vec   = spike_vec_q;
`endif

endmodule

// File: tb/tb_xadc_mux_scan_sequencer.sv
// Directed bench for xadc_mux_scan_sequencer: table of single-channel scans
// plus hand-written multi-channel, zero-mask, continuous and reset sequences.
module tb_xadc_mux_scan_sequencer;

    localparam int SETTLE = 4;
    localparam int EOC_TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] ch_mask = '0;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] drp_do = '0;
    logic [3:0]  mux_addr;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        result_wr;
    logic [3:0]  result_ch;
    logic [11:0] result_data;
    logic        result_err;
    logic        busy;
    logic        scan_done;
`ifdef THRESHOLD_EN
    logic [11:0] threshold = 12'h800;
    logic [15:0] spike_vec;
`endif

    xadc_mux_scan_sequencer #(
        .NUM_CH(16), .SETTLE_CYCLES(SETTLE), .EOC_TIMEOUT(EOC_TO), .DRP_ADDR(7'h03)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
`ifdef THRESHOLD_EN
        .threshold(threshold), .spike_vec(spike_vec),
`endif
        .start(start), .continuous(continuous), .ch_mask(ch_mask),
        .eoc(eoc), .drp_drdy(drdy), .drp_do(drp_do),
        .mux_addr(mux_addr), .drp_den(drp_den), .drp_daddr(drp_daddr),
        .result_wr(result_wr), .result_ch(result_ch), .result_data(result_data),
        .result_err(result_err), .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Captured activity of the last run.
    int          w_n, den_n, done_n, done_cyc, busy_cnt;
    logic [3:0]  w_ch[8];
    logic [3:0]  w_mux[8];
    logic [11:0] w_data[8];
    logic        w_err[8];
    int          w_cyc[8];
    logic        w_done[8];
    logic        w_busy[8];
    logic        busy1;
    logic [3:0]  mux1, mux_last;

    typedef struct {
        logic [15:0] mask;
        int          eoc_dly;   // -1: never
        int          drdy_dly;
        bit          early;     // extra eoc pulse during SETTLE
        logic [15:0] dval;
        logic [3:0]  ech;
        logic [11:0] edata;
        logic        eerr;
        int          ecyc;      // result_wr cycle, counted from start edge
        int          eden;
    } vec_t;

    vec_t tv[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mux"}, 32'(mux_addr), 0);
        chk({tag, "_den"}, 32'(drp_den), 0);
        chk({tag, "_daddr"}, 32'(drp_daddr), 32'h03);
        chk({tag, "_wr"}, 32'(result_wr), 0);
        chk({tag, "_ch"}, 32'(result_ch), 0);
        chk({tag, "_data"}, 32'(result_data), 0);
        chk({tag, "_err"}, 32'(result_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(scan_done), 0);
`ifdef THRESHOLD_EN
        chk({tag, "_spike"}, 32'(spike_vec), 0);
`endif
    endtask

    // Start a scan and act as the XADC: eoc eoc_dly cycles after WAIT_EOC
    // becomes eligible, drdy drdy_dly cycles after the first eligible cycle.
    task automatic run(input logic [15:0] m, input logic [15:0] m2, input bit cont,
                       input int drop_after, input int eoc_dly, input int drdy_dly,
                       input bit early, input logic [15:0] dval, input logic [15:0] dval2);
        int settle_start, eoc_at, drdy_at, tail;
        bit fin;
        w_n = 0; den_n = 0; done_n = 0; done_cyc = -1; busy_cnt = 0;
        start = 1'b1; ch_mask = m; continuous = cont; drp_do = dval;
        step();
        start = 1'b0; ch_mask = m2;
        settle_start = 1;
        eoc_at = (eoc_dly < 0) ? -1 : settle_start + SETTLE + 1 + eoc_dly;
        drdy_at = -1; tail = 0; fin = 1'b0;
        for (int n = 1; n <= 400 && !fin; n++) begin
            if (n == 1) begin busy1 = busy; mux1 = mux_addr; end
            if (busy) busy_cnt++;
            if (drp_den) begin den_n++; drdy_at = n + 1 + drdy_dly; end
            if (scan_done) begin done_n++; done_cyc = n; end
            if (result_wr) begin
                if (w_n < 8) begin
                    w_ch[w_n] = result_ch; w_mux[w_n] = mux_addr;
                    w_data[w_n] = result_data; w_err[w_n] = result_err;
                    w_cyc[w_n] = n; w_done[w_n] = scan_done; w_busy[w_n] = busy;
                end
                w_n++;
                drp_do = dval2;
                if (w_n == drop_after) continuous = 1'b0;
                if (busy) begin
                    settle_start = n + 1;
                    eoc_at = (eoc_dly < 0) ? -1 : settle_start + SETTLE + 1 + eoc_dly;
                end
            end
            if (!busy) tail++; else tail = 0;
            if (tail >= 3) fin = 1'b1;
            eoc  = (n == eoc_at) || (early && n == 3);
            drdy = (n == drdy_at);
            if (!fin) step();
        end
        eoc = 1'b0; drdy = 1'b0; continuous = 1'b0;
        chk("run_bound", 32'(fin), 1);
        mux_last = mux_addr;
    endtask

    initial begin
        tv[0] = '{16'h0001,  0, 0, 1'b0, 16'hABC0, 4'd0,  12'hABC, 1'b0,  9, 1};
        tv[1] = '{16'h0008, -1, 0, 1'b0, 16'h1230, 4'd3,  12'hFFF, 1'b1, 26, 0};
        tv[2] = '{16'h8000,  3, 2, 1'b0, 16'h1234, 4'd15, 12'h123, 1'b0, 14, 1};
        tv[3] = '{16'h0010,  0, 0, 1'b1, 16'hFFF0, 4'd4,  12'hFFF, 1'b0,  9, 1};
        tv[4] = '{16'h0100, 19, 0, 1'b0, 16'h5A50, 4'd8,  12'h5A5, 1'b0, 28, 1};

        #12;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        step(); step();

        // Single-channel scans.
        for (int k = 0; k < 5; k++) begin
            run(tv[k].mask, tv[k].mask, 1'b0, 0, tv[k].eoc_dly, tv[k].drdy_dly,
                tv[k].early, tv[k].dval, tv[k].dval);
            chk($sformatf("v%0d_nwr", k), 32'(w_n), 1);
            chk($sformatf("v%0d_ch", k), 32'(w_ch[0]), 32'(tv[k].ech));
            chk($sformatf("v%0d_data", k), 32'(w_data[0]), 32'(tv[k].edata));
            chk($sformatf("v%0d_err", k), 32'(w_err[0]), 32'(tv[k].eerr));
            chk($sformatf("v%0d_cyc", k), 32'(w_cyc[0]), 32'(tv[k].ecyc));
            chk($sformatf("v%0d_done_wr", k), 32'(w_done[0]), 1);
            chk($sformatf("v%0d_busy_wr", k), 32'(w_busy[0]), 0);
            chk($sformatf("v%0d_busy1", k), 32'(busy1), 1);
            chk($sformatf("v%0d_mux1", k), 32'(mux1), 32'(tv[k].ech));
            chk($sformatf("v%0d_den", k), 32'(den_n), 32'(tv[k].eden));
            chk($sformatf("v%0d_busycnt", k), 32'(busy_cnt), 32'(tv[k].ecyc - 1));
            chk($sformatf("v%0d_ndone", k), 32'(done_n), 1);
        end

        // Two channels, eoc two cycles into WAIT_EOC.
        run(16'h0005, 16'h0005, 1'b0, 0, 2, 0, 1'b0, 16'hABC0, 16'hABC0);
        chk("m_nwr", 32'(w_n), 2);
        chk("m_ch0", 32'(w_ch[0]), 0);
        chk("m_ch1", 32'(w_ch[1]), 2);
        chk("m_mux0", 32'(w_mux[0]), 0);
        chk("m_mux1", 32'(w_mux[1]), 2);
        chk("m_data0", 32'(w_data[0]), 32'hABC);
        chk("m_data1", 32'(w_data[1]), 32'hABC);
        chk("m_cyc0", 32'(w_cyc[0]), 11);
        chk("m_cyc1", 32'(w_cyc[1]), 22);
        chk("m_done0", 32'(w_done[0]), 0);
        chk("m_done1", 32'(w_done[1]), 1);
        chk("m_ndone", 32'(done_n), 1);
        chk("m_den", 32'(den_n), 2);
        chk("m_busycnt", 32'(busy_cnt), 21);
        chk("m_mux_hold", 32'(mux_last), 2);

        // Zero mask: scan_done next cycle, never busy, no DRP.
        run(16'h0000, 16'h0000, 1'b0, 0, 0, 0, 1'b0, 16'h0, 16'h0);
        chk("z_nwr", 32'(w_n), 0);
        chk("z_ndone", 32'(done_n), 1);
        chk("z_donecyc", 32'(done_cyc), 1);
        chk("z_busy", 32'(busy_cnt), 0);
        chk("z_den", 32'(den_n), 0);
        chk("z_mux_hold", 32'(mux_addr), 2);

        // Continuous: mask 0001 then 0002 relatched at the boundary, dropped after.
        run(16'h0001, 16'h0002, 1'b1, 1, 0, 0, 1'b0, 16'hABC0, 16'hABC0);
        chk("c_nwr", 32'(w_n), 2);
        chk("c_ch0", 32'(w_ch[0]), 0);
        chk("c_ch1", 32'(w_ch[1]), 1);
        chk("c_done0", 32'(w_done[0]), 1);
        chk("c_busy0", 32'(w_busy[0]), 1);
        chk("c_done1", 32'(w_done[1]), 1);
        chk("c_busy1", 32'(w_busy[1]), 0);
        chk("c_cyc1", 32'(w_cyc[1]), 18);
        chk("c_busycnt", 32'(busy_cnt), 17);
        chk("c_ndone", 32'(done_n), 2);

`ifdef THRESHOLD_EN
        // ch1 0x900 >= 0x800 sets, ch2 0x7FF clears; ch0/ch4 keep earlier flags.
        run(16'h0006, 16'h0006, 1'b0, 0, 0, 0, 1'b0, 16'h9000, 16'h7FF0);
        chk("t_nwr", 32'(w_n), 2);
        chk("t_spike1", 32'(spike_vec[1]), 1);
        chk("t_spike2", 32'(spike_vec[2]), 0);
        chk("t_spike_all", 32'(spike_vec), 32'h0013);
`endif

        // Reset while waiting for drdy: immediate clear, late drdy ignored.
        begin
            int late_wr;
            late_wr = 0;
            start = 1'b1; ch_mask = 16'h0004;
            step();
            start = 1'b0;
            for (int n = 1; n < 6; n++) step();
            eoc = 1'b1;
            step();
            eoc = 1'b0;
            chk("r_den", 32'(drp_den), 1);
            step();
            chk("r_busy_pre", 32'(busy), 1);
            #2 rst_n = 1'b0;
            #1;
            chk_reset_vals("arst");
            step();
            rst_n = 1'b1;
            drdy = 1'b1; drp_do = 16'h4440;
            step();
            drdy = 1'b0;
            for (int n = 0; n < 6; n++) begin
                if (result_wr || scan_done || busy) late_wr++;
                step();
            end
            chk("r_no_late", 32'(late_wr), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
